ram_controller: RTL and testbench

Bus initiator that drives the 512×32 synchronous `RAM` block on behalf of the CPU datapath. It converts single-word or burst read/write requests into cycle-accurate `Read`/`Write` strobes and handles the RAM's one-cycle registered read latency. Read data comes back as a streamed, registered response with a completion pulse. The block sits between the datapath's memory-access logic (MAR/MDR side) and the RAM.

---
 rtl/ram_controller.sv | 138 +++++++++++++
 tb/tb_ram_controller.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_controller.sv
// ram_controller: bus initiator for the 512x32 synchronous RAM.
// Converts single-word or burst read/write requests into Read/Write strobes,
// absorbs the RAM's one-cycle read latency and streams registered read data.
// Build option: define RAM_CTRL_BURST_EN to honour `len` (1..2^LEN_W words);
// without it every transfer moves exactly one word.
module ram_controller #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_DRAIN,
    S_WR
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_cur_addr;
  logic              r_issued;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_done;
  logic              w_last;

`ifdef RAM_CTRL_BURST_EN
  logic [LEN_W:0]    r_remaining;

  assign w_last = (r_remaining == (LEN_W+1)'(1));

  // Words left in the burst, loaded with len+1 on acceptance.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_remaining <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) r_remaining <= {1'b0, len} + (LEN_W+1)'(1);
    end else if (mem_read || mem_write) begin
      r_remaining <= r_remaining - (LEN_W+1)'(1);
    end
  end
`else
  logic w_unused_len;

  assign w_unused_len = ^len;
  assign w_last       = 1'b1;
`endif

  assign wr_ack   = mem_write;
  assign mem_din  = wr_data;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign done     = r_done;

  // State register.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and strobe decode.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = rw ? S_WR : S_RD;
      end
      S_RD: begin
        mem_read = 1'b1;
        mem_addr = r_cur_addr;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_next = S_IDLE;
      end
      S_WR: begin
        mem_write = 1'b1;
        mem_addr  = r_cur_addr;
        if (w_last) w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // Current address: latched on acceptance, stepped on every strobe (wraps).
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cur_addr <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) r_cur_addr <= addr;
    end else if (mem_read || mem_write) begin
      r_cur_addr <= r_cur_addr + ADDR_W'(1);
    end
  end

  // Read capture one edge after each issue edge, plus completion pulse.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_issued   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_issued   <= mem_read;
      r_rd_valid <= r_issued;
      if (r_issued) r_rd_data <= mem_dout;
      r_done     <= (r_state == S_DRAIN) || ((r_state == S_WR) && w_last);
    end
  end

endmodule

// File: tb/tb_ram_controller.sv
// Scoreboard bench for ram_controller with a behavioural RAM and a reference
// memory; adapts the expected word count to the RAM_CTRL_BURST_EN build.
module tb_ram_controller;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int DEPTH  = 512;

  logic              clock = 1'b0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic              rw = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout = '0;

  ram_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .clear(clear), .start(start), .rw(rw), .addr(addr),
    .len(len), .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural synchronous RAM with a backdoor port for preloading.
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              bd_en = 1'b0;
  logic [ADDR_W-1:0] bd_addr = '0;
  logic [DATA_W-1:0] bd_data = '0;

  always @(posedge clock) begin
    if (bd_en) ram[bd_addr] <= bd_data;
    else if (mem_write) ram[mem_addr] <= mem_din;
    if (mem_read) mem_dout <= ram[mem_addr];
  end

  typedef struct {
    int          cyc;
    logic [8:0]  a;
    logic [31:0] d;
  } ev_t;

  ev_t q_iss[$];
  ev_t q_rd[$];
  ev_t q_wr[$];
  ev_t q_done[$];
  ev_t m_e;

  int checks = 0;
  int passed = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endfunction

  function automatic void flag(string name);
    checks++;
    $display("FAIL %s: observed an event that no request expected at %0t", name, $time);
  endfunction

  // Monitor: compares every strobe, read word and completion to the queues.
  always @(negedge clock) begin
    if (clear) begin
      if (mem_read && mem_write) flag("strobe_overlap");
      if (mem_read) begin
        if (q_iss.size() == 0) flag("extra_read_strobe");
        else begin
          m_e = q_iss.pop_front();
          chk("rd_issue_addr", 64'(mem_addr), 64'(m_e.a));
          chk("rd_issue_cycle", 64'(cyc), 64'(m_e.cyc));
        end
      end
      if (mem_write) begin
        if (q_wr.size() == 0) flag("extra_write_strobe");
        else begin
          m_e = q_wr.pop_front();
          chk("wr_addr", 64'(mem_addr), 64'(m_e.a));
          chk("wr_data", 64'(mem_din), 64'(m_e.d));
          chk("wr_cycle", 64'(cyc), 64'(m_e.cyc));
          chk("wr_ack", 64'(wr_ack), 64'(1));
        end
      end
      if (rd_valid) begin
        if (q_rd.size() == 0) flag("extra_rd_valid");
        else begin
          m_e = q_rd.pop_front();
          chk("rd_data", 64'(rd_data), 64'(m_e.d));
          chk("rd_cycle", 64'(cyc), 64'(m_e.cyc));
        end
      end
      if (done) begin
        if (q_done.size() == 0) flag("extra_done");
        else begin
          m_e = q_done.pop_front();
          chk("done_cycle", 64'(cyc), 64'(m_e.cyc));
          chk("done_busy_low", 64'(busy), 64'(0));
          if (m_e.d == 32'd1) chk("done_with_rd_valid", 64'(rd_valid), 64'(1));
        end
      end
    end
  end

  function automatic int words(input logic [3:0] l);
`ifdef RAM_CTRL_BURST_EN
    return int'(l) + 1;
`else
    return 1;
`endif
  endfunction

  // One transfer: push expectations, strobe start, feed write data until idle.
  task automatic run(input bit w, input logic [8:0] a, input logic [3:0] l,
                     input bit poke, input bit fixed);
    int          n, c0, k, guard;
    bit          ack;
    logic [8:0]  ak;
    logic [31:0] d;
    logic [31:0] wd[$];
    ev_t         e;
    n  = words(l);
    c0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      ak = a + 9'(i);
      if (w) begin
        d = fixed ? 32'h11 * 32'(i + 1) : $urandom;
        wd.push_back(d);
        ref_mem[ak] = d;
        e.cyc = c0 + i; e.a = ak; e.d = d;
        q_wr.push_back(e);
      end else begin
        e.cyc = c0 + i; e.a = ak; e.d = '0;
        q_iss.push_back(e);
        e.cyc = c0 + i + 2; e.d = ref_mem[ak];
        q_rd.push_back(e);
      end
    end
    e.cyc = w ? c0 + n : c0 + n + 1; e.a = '0; e.d = w ? 32'd0 : 32'd1;
    q_done.push_back(e);
    rw = w; addr = a; len = l;
    if (w) wr_data = wd[0];
    else   wr_data = $urandom;
    start = 1'b1;
    @(posedge clock); #1;
    if (poke) begin
      rw = ~w; addr = 9'($urandom); len = 4'($urandom);
    end else start = 1'b0;
    k = 0; guard = 0;
    while (busy && guard < 100) begin
      @(negedge clock); ack = wr_ack;
      @(posedge clock); #1;
      start = 1'b0;
      if (ack) begin
        k++;
        if (k < n) wr_data = wd[k];
      end
      guard++;
    end
    start = 1'b0;
    if (guard >= 100) flag("busy_timeout");
  endtask

  // 8-word write interrupted by clear right after its third write edge.
  task automatic reset_mid_write();
    int          n, nw, c0, k;
    bit          ack;
    logic [8:0]  a, ak;
    logic [31:0] d;
    logic [31:0] wd[$];
    ev_t         e;
    n  = words(4'd7);
    nw = (n < 3) ? n : 3;
    a  = 9'($urandom);
    c0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      wd.push_back(d);
      if (i < nw) begin
        ak = a + 9'(i);
        ref_mem[ak] = d;
        e.cyc = c0 + i; e.a = ak; e.d = d;
        q_wr.push_back(e);
      end
    end
    if (n < 3) begin
      e.cyc = c0 + n; e.a = '0; e.d = 32'd0;
      q_done.push_back(e);
    end
    rw = 1'b1; addr = a; len = 4'd7; wr_data = wd[0]; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    k = 0;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock); ack = wr_ack;
      @(posedge clock); #1;
      if (ack) begin
        k++;
        if (k < n) wr_data = wd[k];
      end
    end
    clear = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(busy), 64'(0));
    chk("rst_mid_done", 64'(done), 64'(0));
    chk("rst_mid_rd_valid", 64'(rd_valid), 64'(0));
    chk("rst_mid_wr_ack", 64'(wr_ack), 64'(0));
    chk("rst_mid_mem_read", 64'(mem_read), 64'(0));
    chk("rst_mid_mem_write", 64'(mem_write), 64'(0));
    chk("rst_mid_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mid_rd_data", 64'(rd_data), 64'(0));
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bad;
    logic [31:0] v;
    for (int i = 0; i < DEPTH; i++) begin
      v = (i == 16) ? 32'hDEADBEEF : $urandom;
      bd_en = 1'b1; bd_addr = 9'(i); bd_data = v;
      ref_mem[i] = v;
      @(posedge clock); #1;
    end
    bd_en = 1'b0;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_rd_valid", 64'(rd_valid), 64'(0));
    chk("reset_wr_ack", 64'(wr_ack), 64'(0));
    chk("reset_mem_read", 64'(mem_read), 64'(0));
    chk("reset_mem_write", 64'(mem_write), 64'(0));
    chk("reset_mem_addr", 64'(mem_addr), 64'(0));
    chk("reset_rd_data", 64'(rd_data), 64'(0));
    clear = 1'b1;
    @(posedge clock); #1;

    run(1'b0, 9'h010, 4'd0, 1'b0, 1'b0);
    run(1'b1, 9'h1FE, 4'd3, 1'b0, 1'b1);
    run(1'b0, 9'h1FE, 4'd3, 1'b0, 1'b0);
    run(1'b0, 9'h100, 4'd15, 1'b0, 1'b0);
    run(1'b0, 9'h080, 4'd4, 1'b1, 1'b0);
    run(1'b0, 9'h020, 4'd7, 1'b0, 1'b0);
    reset_mid_write();
    run(1'b0, 9'h010, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run(1'($urandom), 9'($urandom), 4'($urandom), ($urandom % 4) == 0, 1'b0);
      repeat ($urandom % 3) begin
        @(posedge clock); #1;
      end
    end

    repeat (5) begin
      @(posedge clock); #1;
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_contents_mismatches", 64'(bad), 64'(0));
    chk("scoreboard_drained",
        64'(q_iss.size() + q_rd.size() + q_wr.size() + q_done.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
